// File: rtl/serial_tx_8bit_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter.
package ser_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter needs at least one bit even for a single-bit word.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_8bit_if.sv
// Word handshake plus serial-side outputs of serial_tx_8bit.
interface serial_tx_8bit_if
  import ser_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [DATA_W-1:0] DIn;
  logic              DValid;
  logic              DReady;
  logic              SID;
  logic              SEn;
  logic              Busy;
  logic              Done;

  modport master (
    output DIn, DValid,
    input  DReady, SID, SEn, Busy, Done
  );

  modport slave (
    input  DIn, DValid,
    output DReady, SID, SEn, Busy, Done
  );

endinterface

// File: rtl/serial_tx_8bit_bit_counter.sv
// Bit position counter: sync clear, enable, saturates at DATA_W-1 and flags it.
module bit_counter
  import ser_pkg::*;
#(
  parameter int  DATA_W = DEFAULT_DATA_W,
  localparam int CNT_W  = cnt_width(DATA_W)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clk) begin
    if (Rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/serial_tx_8bit.sv
// Serializes one DATA_W-bit word per handshake onto SID, qualified by SEn,
// followed by a one-cycle Done pulse.
module serial_tx_8bit
  import ser_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int LSB_FIRST = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  serial_tx_8bit_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic              r_sid;
  logic              r_sen;
  logic              r_done;
  logic              w_ready;
  logic              w_hs;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_tc;

  function automatic logic lead_bit(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  // Gating with Rst keeps a handshake offered during reset from being taken.
  assign w_ready = (r_state == IDLE) && !Rst;
  assign w_hs    = bus.DValid && w_ready;

  bit_counter #(
    .DATA_W (DATA_W)
  ) u_bit_counter (
    .Clk   (Clk),
    .Rst   (Rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_state_nxt = SHIFT;
          w_shreg_nxt = bus.DIn;
          w_cnt_clr   = 1'b1;
        end
      end
      SHIFT: begin
        w_cnt_en    = 1'b1;
        w_shreg_nxt = shift_next(r_shreg);
        if (w_tc) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so SID always equals the
  // leading bit of the shift register while in SHIFT.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_sid   <= 1'b0;
      r_sen   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_sid   <= (w_state_nxt == SHIFT) ? lead_bit(w_shreg_nxt) : 1'b0;
      r_sen   <= (w_state_nxt == SHIFT);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  assign bus.DReady = w_ready;
  assign bus.SID    = r_sid;
  assign bus.SEn    = r_sen;
  assign bus.Busy   = (r_state != IDLE);
  assign bus.Done   = r_done;

endmodule

// File: tb/tb_serial_tx_8bit.sv
// Directed bench for serial_tx_8bit: one LSB-first and one MSB-first instance.
module tb_serial_tx_8bit;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [7:0] q_l;
  logic [7:0] q_m;

  serial_tx_8bit_if #(.DATA_W(8)) if_l ();
  serial_tx_8bit_if #(.DATA_W(8)) if_m ();

  serial_tx_8bit #(.DATA_W(8), .LSB_FIRST(1)) u_lsb (.Clk(clk), .Rst(rst), .bus(if_l));
  serial_tx_8bit #(.DATA_W(8), .LSB_FIRST(0)) u_msb (.Clk(clk), .Rst(rst), .bus(if_m));

  always #5 clk = ~clk;

  // Downstream 8-bit shift registers fed by each transmitter.
  always @(posedge clk) begin
    if (if_l.SEn) q_l <= {if_l.SID, q_l[7:1]};
    if (if_m.SEn) q_m <= {q_m[6:0], if_m.SID};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit msb, output logic sid, output logic sen,
                        output logic busy, output logic done, output logic rdy);
    if (msb) begin
      sid = if_m.SID; sen = if_m.SEn; busy = if_m.Busy; done = if_m.Done; rdy = if_m.DReady;
    end else begin
      sid = if_l.SID; sen = if_l.SEn; busy = if_l.Busy; done = if_l.Done; rdy = if_l.DReady;
    end
  endtask

  // Hand one word over, then observe 12 cycles; cycle 1 is the one after the handshake edge.
  task automatic run_word(input bit msb, input logic [7:0] d, output logic [7:0] seq,
                          output int nsen, output int done_cyc, output int rdy_cyc,
                          output int busy_cyc, output int stray);
    logic sid, sen, busy, done, rdy;
    seq = 8'h00; nsen = 0; done_cyc = 0; rdy_cyc = 0; busy_cyc = 0; stray = 0;
    if (msb) begin if_m.DIn = d; if_m.DValid = 1'b1; end
    else     begin if_l.DIn = d; if_l.DValid = 1'b1; end
    tick();
    if_m.DValid = 1'b0;
    if_l.DValid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      sample(msb, sid, sen, busy, done, rdy);
      if (sen) begin
        seq = {seq[6:0], sid};
        nsen++;
      end else if (sid) begin
        stray++;
      end
      if (done && done_cyc == 0) done_cyc = c;
      if (rdy && rdy_cyc == 0) rdy_cyc = c;
      if (busy) busy_cyc++;
      if (c < 12) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_l.DValid = 1'b1; if_l.DIn = 8'hA5;
    if_m.DValid = 1'b1; if_m.DIn = 8'h81;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({if_l.DReady, if_l.SID, if_l.SEn, if_l.Busy, if_l.Done} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outs_lsb cyc%0d: got %b expected 00000", i,
                 {if_l.DReady, if_l.SID, if_l.SEn, if_l.Busy, if_l.Done});
      end
      checks++;
      if ({if_m.DReady, if_m.SID, if_m.SEn, if_m.Busy, if_m.Done} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outs_msb cyc%0d: got %b expected 00000", i,
                 {if_m.DReady, if_m.SID, if_m.SEn, if_m.Busy, if_m.Done});
      end
    end
    if_l.DValid = 1'b0;
    if_m.DValid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (if_l.DReady !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready_lsb: got %b expected 1", if_l.DReady);
    end
    checks++;
    if (if_m.DReady !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready_msb: got %b expected 1", if_m.DReady);
    end
    tick();
    checks++;
    if ({if_l.Busy, if_l.SEn, if_l.Done} !== 3'b000) begin
      errors++; $display("FAIL reset_no_transfer_lsb: got %b expected 000", {if_l.Busy, if_l.SEn, if_l.Done});
    end
    checks++;
    if ({if_m.Busy, if_m.SEn, if_m.Done} !== 3'b000) begin
      errors++; $display("FAIL reset_no_transfer_msb: got %b expected 000", {if_m.Busy, if_m.SEn, if_m.Done});
    end
  endtask

  task automatic test_single_lsb();
    logic [7:0] seq;
    int nsen, done_cyc, rdy_cyc, busy_cyc, stray;
    run_word(1'b0, 8'hA5, seq, nsen, done_cyc, rdy_cyc, busy_cyc, stray);
    checks++;
    if (seq !== 8'b1010_0101) begin errors++; $display("FAIL single_seq: got %b expected 10100101", seq); end
    checks++;
    if (nsen !== 8) begin errors++; $display("FAIL single_nsen: got %0d expected 8", nsen); end
    checks++;
    if (done_cyc !== 9) begin errors++; $display("FAIL single_done_cycle: got %0d expected 9", done_cyc); end
    checks++;
    if (rdy_cyc !== 10) begin errors++; $display("FAIL single_ready_cycle: got %0d expected 10", rdy_cyc); end
    checks++;
    if (busy_cyc !== 9 || stray !== 0) begin
      errors++; $display("FAIL single_busy_stray: got busy=%0d stray=%0d expected busy=9 stray=0", busy_cyc, stray);
    end
    checks++;
    if (q_l !== 8'hA5) begin errors++; $display("FAIL single_downstream_q: got %h expected a5", q_l); end
  endtask

  task automatic test_msb_first();
    logic [7:0] seq;
    int nsen, done_cyc, rdy_cyc, busy_cyc, stray;
    run_word(1'b1, 8'h81, seq, nsen, done_cyc, rdy_cyc, busy_cyc, stray);
    checks++;
    if (seq !== 8'b1000_0001) begin errors++; $display("FAIL msb_seq_81: got %b expected 10000001", seq); end
    checks++;
    if (nsen !== 8 || done_cyc !== 9) begin
      errors++; $display("FAIL msb_timing_81: got nsen=%0d done=%0d expected 8/9", nsen, done_cyc);
    end
    run_word(1'b1, 8'h0F, seq, nsen, done_cyc, rdy_cyc, busy_cyc, stray);
    checks++;
    if (seq !== 8'b0000_1111) begin errors++; $display("FAIL msb_seq_0f: got %b expected 00001111", seq); end
    checks++;
    if (q_m !== 8'h0F) begin errors++; $display("FAIL msb_downstream_q: got %h expected 0f", q_m); end
    checks++;
    if (rdy_cyc !== 10 || stray !== 0) begin
      errors++; $display("FAIL msb_ready_stray: got rdy=%0d stray=%0d expected 10/0", rdy_cyc, stray);
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] sen_pat;
    logic [15:0] seq;
    int ndone;
    sen_pat = '0; seq = '0; ndone = 0;
    if_l.DIn = 8'h3C;
    if_l.DValid = 1'b1;
    tick();
    if_l.DIn = 8'hC3;
    for (int c = 1; c <= 22; c++) begin
      sen_pat = {sen_pat[20:0], if_l.SEn};
      if (if_l.SEn) seq = {seq[14:0], if_l.SID};
      if (if_l.Done) ndone++;
      if (c == 11) if_l.DValid = 1'b0;
      if (c < 22) tick();
    end
    checks++;
    if (sen_pat !== 22'b11111111_00_11111111_0000) begin
      errors++; $display("FAIL b2b_sen_pattern: got %b expected 1111111100111111110000", sen_pat);
    end
    checks++;
    if (seq !== 16'h3CC3) begin errors++; $display("FAIL b2b_bits: got %h expected 3cc3", seq); end
    checks++;
    if (ndone !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    checks++;
    if (q_l !== 8'hC3) begin errors++; $display("FAIL b2b_downstream_q: got %h expected c3", q_l); end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] seq;
    int nsen;
    seq = '0; nsen = 0;
    if_l.DIn = 8'h00;
    if_l.DValid = 1'b1;
    tick();
    if_l.DValid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (if_l.SEn) begin seq = {seq[6:0], if_l.SID}; nsen++; end
      if (c == 3) begin if_l.DIn = 8'hFF; if_l.DValid = 1'b1; end
      if (c == 8) if_l.DValid = 1'b0;
      if (c < 12) tick();
    end
    checks++;
    if (seq !== 8'h00 || nsen !== 8) begin
      errors++; $display("FAIL ignore_bits: got seq=%b nsen=%0d expected 00000000/8", seq, nsen);
    end
    checks++;
    if (if_l.Busy !== 1'b0) begin errors++; $display("FAIL ignore_no_second_word: got busy=%b expected 0", if_l.Busy); end
    checks++;
    if (q_l !== 8'h00) begin errors++; $display("FAIL ignore_downstream_q: got %h expected 00", q_l); end
  endtask

  task automatic test_abort();
    logic [7:0] seq;
    int nsen, done_cyc, rdy_cyc, busy_cyc, stray, ndone, nsen_after;
    if_l.DIn = 8'hFF;
    if_l.DValid = 1'b1;
    tick();
    if_l.DValid = 1'b0;
    for (int c = 1; c <= 3; c++) tick();
    checks++;
    if ({if_l.SEn, if_l.SID} !== 2'b11) begin
      errors++; $display("FAIL abort_4th_bit: got sen,sid=%b expected 11", {if_l.SEn, if_l.SID});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({if_l.SID, if_l.SEn, if_l.Busy, if_l.Done, if_l.DReady} !== 5'b0) begin
      errors++; $display("FAIL abort_outs: got %b expected 00000",
                         {if_l.SID, if_l.SEn, if_l.Busy, if_l.Done, if_l.DReady});
    end
    rst = 1'b0;
    ndone = 0; nsen_after = 0;
    for (int c = 0; c < 6; c++) begin
      if (if_l.Done) ndone++;
      if (if_l.SEn) nsen_after++;
      tick();
    end
    checks++;
    if (ndone !== 0 || nsen_after !== 0) begin
      errors++; $display("FAIL abort_no_done: got done=%0d sen=%0d expected 0/0", ndone, nsen_after);
    end
    run_word(1'b0, 8'h55, seq, nsen, done_cyc, rdy_cyc, busy_cyc, stray);
    checks++;
    if (seq !== 8'b1010_1010 || nsen !== 8) begin
      errors++; $display("FAIL abort_next_bits: got seq=%b nsen=%0d expected 10101010/8", seq, nsen);
    end
    checks++;
    if (q_l !== 8'h55 || done_cyc !== 9) begin
      errors++; $display("FAIL abort_next_word: got q=%h done=%0d expected 55/9", q_l, done_cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    errors = 0;
    checks = 0;
    if_l.DIn = '0; if_l.DValid = 1'b0;
    if_m.DIn = '0; if_m.DValid = 1'b0;
    test_reset();
    test_single_lsb();
    test_msb_first();
    test_back_to_back();
    test_ignore_busy();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
